// File: rtl/psum_collector.sv
// Collects NUM_PASSES saturating partial sums per output value from a PE column and queues results in a FIFO.
// Optional: define PSUM_COLLECTOR_RELU_EN to rectify values (after saturation) as they are pushed.
module psum_collector #(
    parameter int BITWIDTH        = 16,
    parameter int NUM_PASSES      = 3,
    parameter int FIFO_ADDR_WIDTH = 2,
    localparam int CNT_W          = $clog2(NUM_PASSES + 1)
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                pe_ready,
    input  logic [BITWIDTH-1:0] pe_psum,
    input  logic                clear,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] out_data,
    output logic [CNT_W-1:0]    pass_cnt,
    output logic                sat_flag,
    output logic                drop_flag,
    output logic                state_dbg
);

    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam logic [BITWIDTH-1:0] MAX_V = {1'b0, {(BITWIDTH-1){1'b1}}};
    localparam logic [BITWIDTH-1:0] MIN_V = {1'b1, {(BITWIDTH-1){1'b0}}};
    localparam logic [FIFO_ADDR_WIDTH:0] FULL_CNT = (FIFO_ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

    state_t                     state_q, state_d;
    logic                       ready_d_q;
    logic [BITWIDTH-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]           pass_cnt_q, pass_cnt_d;
    logic                       sat_q, sat_d;
    logic                       drop_q, drop_d;
    logic [BITWIDTH-1:0]        mem_q [DEPTH];
    logic [BITWIDTH-1:0]        mem_d [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0] rd_next;
    logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;
    logic [BITWIDTH-1:0]        out_data_q, out_data_d;

    logic                capture;
    logic [BITWIDTH:0]   sum_wide;
    logic                ovf;
    logic [BITWIDTH-1:0] sum_sat;
    logic [BITWIDTH-1:0] push_val;
    logic                last_pass;
    logic                push_req;
    logic                push_ok;
    logic                pop;
    logic                full;

    // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
    always_comb begin
        capture   = pe_ready & ~ready_d_q;
        sum_wide  = {acc_q[BITWIDTH-1], acc_q} + {pe_psum[BITWIDTH-1], pe_psum};
        ovf       = sum_wide[BITWIDTH] ^ sum_wide[BITWIDTH-1];
        sum_sat   = ovf ? (sum_wide[BITWIDTH] ? MIN_V : MAX_V) : sum_wide[BITWIDTH-1:0];
        last_pass = (int'(pass_cnt_q) + 1) == NUM_PASSES;
`ifdef PSUM_COLLECTOR_RELU_EN
        push_val  = sum_sat[BITWIDTH-1] ? '0 : sum_sat;
`else
        push_val  = sum_sat;
`endif
        push_req  = capture & ~clear & last_pass;
        pop       = out_ready & (count_q != '0);
        full      = (count_q == FULL_CNT);
        push_ok   = push_req & (~full | pop);
        rd_next   = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        pass_cnt_d = pass_cnt_q;
        sat_d      = sat_q;
        drop_d     = drop_q;
        if (clear) begin
            state_d    = S_IDLE;
            acc_d      = '0;
            pass_cnt_d = '0;
        end else if (capture) begin
            if (ovf) sat_d = 1'b1;
            if (last_pass) begin
                state_d    = S_IDLE;
                acc_d      = '0;
                pass_cnt_d = '0;
            end else begin
                state_d    = S_ACCUM;
                acc_d      = sum_sat;
                pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end
        end
        if (push_req && !push_ok) drop_d = 1'b1;
    end

    // out_data holds the registered head, so it must look one entry ahead on a pop.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_val;
            wr_ptr_d        = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
        end
        if (pop) rd_ptr_d = rd_next;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (FIFO_ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (FIFO_ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
        if (pop) begin
            if (count_q > (FIFO_ADDR_WIDTH+1)'(1)) out_data_d = mem_q[rd_next];
            else if (push_ok)                      out_data_d = push_val;
        end else if (push_ok && count_q == '0) begin
            out_data_d = push_val;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= S_IDLE;
            ready_d_q  <= 1'b0;
            acc_q      <= '0;
            pass_cnt_q <= '0;
            sat_q      <= 1'b0;
            drop_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ready_d_q  <= pe_ready;
            acc_q      <= acc_d;
            pass_cnt_q <= pass_cnt_d;
            sat_q      <= sat_d;
            drop_q     <= drop_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_data_q;
    assign pass_cnt  = pass_cnt_q;
    assign sat_flag  = sat_q;
    assign drop_flag = drop_q;
    assign state_dbg = (state_q == S_ACCUM);

endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector: reference model pushes expected outputs to a queue, a monitor pops them on each accepted beat.
module tb_psum_collector;

    localparam int W     = 16;
    localparam int NP    = 3;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(NP + 1);
    localparam int MAXV  = (1 << (W-1)) - 1;
    localparam int MINV  = -(1 << (W-1));

    logic          clk = 1'b0;
    logic          rstb;
    logic          pe_ready;
    logic [W-1:0]  pe_psum;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] pass_cnt;
    logic          sat_flag;
    logic          drop_flag;
    logic          state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];
    int acc_m, cnt_m;
    bit sat_m, drop_m;

    psum_collector #(.BITWIDTH(W), .NUM_PASSES(NP), .FIFO_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstb(rstb), .pe_ready(pe_ready), .pe_psum(pe_psum), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .pass_cnt(pass_cnt), .sat_flag(sat_flag), .drop_flag(drop_flag), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    // Samples just before each rising edge, after all drivers have settled.
    always @(negedge clk) begin
        #2;
        if (rstb && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_pop", sx(out_data), 99999);
            else                   check("pop_data", sx(out_data), sx(exp_q.pop_front()));
        end
    end

    task automatic model_capture(input int psum);
        int s;
        s = acc_m + psum;
        if (s > MAXV) begin s = MAXV; sat_m = 1'b1; end
        else if (s < MINV) begin s = MINV; sat_m = 1'b1; end
        cnt_m++;
        if (cnt_m == NP) begin
`ifdef PSUM_COLLECTOR_RELU_EN
            if (s < 0) s = 0;
`endif
            if (exp_q.size() < DEPTH) exp_q.push_back(W'(s));
            else                      drop_m = 1'b1;
            acc_m = 0;
            cnt_m = 0;
        end else begin
            acc_m = s;
        end
    endtask

    task automatic capture(input int psum, input bit pop = 1'b0);
        @(negedge clk);
        pe_psum   = W'(psum);
        pe_ready  = 1'b1;
        out_ready = pop;
        @(posedge clk);
        model_capture(psum);
        @(negedge clk);
        pe_ready  = 1'b0;
        out_ready = 1'b0;
        check("pass_cnt", int'(pass_cnt), cnt_m);
        check("fsm_state", int'(state_dbg), int'(cnt_m != 0));
        @(posedge clk);
    endtask

    task automatic push_value(input int v);
        capture(v);
        for (int i = 1; i < NP; i++) capture(0);
    endtask

    task automatic drain(input int n);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (n) @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", sx(out_data), 0);
        check("rst_pass_cnt", int'(pass_cnt), 0);
        check("rst_sat_flag", int'(sat_flag), 0);
        check("rst_drop_flag", int'(drop_flag), 0);
        check("rst_state", int'(state_dbg), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstb      = 1'b0;
        pe_ready  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        pe_psum   = '0;
        #1;
        check_reset_values();
        exp_q.delete();
        acc_m  = 0;
        cnt_m  = 0;
        sat_m  = 1'b0;
        drop_m = 1'b0;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
    endtask

    initial begin
        rstb      = 1'b0;
        pe_ready  = 1'b0;
        pe_psum   = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        do_reset();

        // Basic three-pass accumulation and a single pop
        capture(38);
        capture(137);
        capture(290);
        @(negedge clk);
        check("t1_valid", int'(out_valid), 1);
        check("t1_data", sx(out_data), 465);
        drain(1);
        check("t1_valid_after_pop", int'(out_valid), 0);

        // Held-high ready counts once
        @(negedge clk);
        pe_psum  = W'(10);
        pe_ready = 1'b1;
        @(posedge clk);
        model_capture(10);
        repeat (4) @(negedge clk);
        check("hold_pass_cnt", int'(pass_cnt), 1);
        @(negedge clk);
        pe_ready = 1'b0;
        check("hold_pass_cnt_end", int'(pass_cnt), 1);
        @(posedge clk);
        capture(20);
        capture(30);
        @(negedge clk);
        check("hold_sum", sx(out_data), 60);
        drain(1);

        // Saturation both ways
        do_reset();
        capture(30000);
        capture(30000);
        capture(1);
        @(negedge clk);
        check("sat_max_data", sx(out_data), 32767);
        check("sat_flag", int'(sat_flag), 1);
        capture(-30000);
        capture(-30000);
        capture(0);
        drain(2);
        check("sat_drained", int'(out_valid), 0);

        // Overflowing the FIFO drops the fifth value
        do_reset();
        for (int v = 1; v <= DEPTH; v++) push_value(v);
        @(negedge clk);
        check("full_no_drop", int'(drop_flag), 0);
        check("full_head", sx(out_data), 1);
        push_value(5);
        @(negedge clk);
        check("drop_flag", int'(drop_flag), 1);
        drain(DEPTH);
        check("drop_drained_valid", int'(out_valid), 0);
        check("drop_sb_empty", exp_q.size(), 0);

        // Final capture while full but popping: no drop
        do_reset();
        for (int v = 11; v <= 14; v++) push_value(v);
        capture(15);
        capture(0);
        capture(0, 1'b1);
        @(negedge clk);
        check("fullpop_no_drop", int'(drop_flag), 0);
        check("fullpop_head", sx(out_data), 12);
        drain(DEPTH);
        check("fullpop_drained", int'(out_valid), 0);
        check("fullpop_sb_empty", exp_q.size(), 0);

        // Clear beats a simultaneous capture
        do_reset();
        capture(10);
        capture(20);
        @(negedge clk);
        pe_psum  = W'(5);
        pe_ready = 1'b1;
        clear    = 1'b1;
        @(posedge clk);
        acc_m = 0;
        cnt_m = 0;
        @(negedge clk);
        clear    = 1'b0;
        pe_ready = 1'b0;
        check("clear_pass_cnt", int'(pass_cnt), 0);
        check("clear_no_push", int'(out_valid), 0);
        @(posedge clk);
        capture(1);
        capture(2);
        capture(3);
        @(negedge clk);
        check("clear_then_sum", sx(out_data), 6);
        check("clear_then_valid", int'(out_valid), 1);
        capture(1);
        capture(2);
        // Asynchronous reset mid-accumulation with a queued value
        do_reset();

        // Random psums with random coincident pops
        do_reset();
        for (int i = 0; i < 10 * NP; i++)
            capture(int'($urandom_range(0, 40000)) - 20000, 1'($urandom_range(0, 1)));
        @(negedge clk);
        check("rand_sat_flag", int'(sat_flag), int'(sat_m));
        check("rand_drop_flag", int'(drop_flag), int'(drop_m));
        drain(DEPTH);
        check("rand_drained", int'(out_valid), 0);
        check("rand_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
